// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detection controller.
//   Holds a run-time pattern/length/mode/target configuration, shifts qualified
//   serial bits into a history register while running, pulses dout on each match
//   and counts matches (saturating). Stops in DONE when the match target is hit.
//
// Optional feature macro: SEQ_DETECT_TIMEOUT_EN
//   defined   -> watchdog over qualified samples; TIMEOUT_CYC samples without a
//                match end the run in DONE with timeout = 1.
//   undefined -> no watchdog logic, timeout tied to 0, TIMEOUT_CYC not present.
//
// Ports:
//   clk, rst                 clock (posedge), synchronous active-high reset
//   cfg_valid, cfg_pat,      config write strobe and fields; accepted when
//   cfg_len, cfg_overlap,    cfg_ready is high (IDLE/DONE)
//   cfg_target
//   cfg_ready                combinational, high outside RUN
//   start, stop              begin a run / abort a run
//   din, din_valid           serial data and its qualifier
//   dout                     one-cycle match pulse (registered)
//   match_cnt                matches in the current run, saturating
//   busy, done, timeout      RUN / DONE status levels, watchdog-end flag
module seq_detect_ctrl #(
    parameter int unsigned       PAT_W       = 4,
    parameter int unsigned       LEN_W       = 3,
    parameter int unsigned       CNT_W       = 8,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(4'b1001)
`ifdef SEQ_DETECT_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_CYC = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_valid,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SEQ_DETECT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // Per-sample candidates used while running
    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [PAT_W-1:0] len_mask;
    logic [CNT_W-1:0] cnt_n;
    logic             match;

    // Pattern length mask: bit i active when i < stored length
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Next-state, config, history and counter logic
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        dout_d    = 1'b0;
        cnt_d     = cnt_q;
`ifdef SEQ_DETECT_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif

        hist_n = {hist_q[PAT_W-2:0], din};
        fill_n = (fill_q >= LEN_MAX) ? fill_q : LEN_W'(fill_q + 1'b1);
        match  = (fill_n >= len_q) && ((hist_n & len_mask) == (pat_q & len_mask));
        cnt_n  = (cnt_q == '1) ? cnt_q : CNT_W'(cnt_q + 1'b1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_valid) begin
                    pat_d     = cfg_pat;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                    if (cfg_len == '0) begin
                        len_d = LEN_W'(1);
                    end else if (cfg_len > LEN_MAX) begin
                        len_d = LEN_MAX;
                    end else begin
                        len_d = cfg_len;
                    end
                    state_d = S_IDLE;
`ifdef SEQ_DETECT_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
                // start wins over the cfg-only DONE->IDLE move; new config applies
                if (start) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
`ifdef SEQ_DETECT_TIMEOUT_EN
                    wd_d      = '0;
                    timeout_d = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Abort drops any same-cycle match
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    hist_d = hist_n;
                    fill_d = fill_n;
                    if (match) begin
                        dout_d = 1'b1;
                        cnt_d  = cnt_n;
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (cnt_n == target_q)) begin
                            state_d = S_DONE;
                        end
`ifdef SEQ_DETECT_TIMEOUT_EN
                        wd_d = '0;
`endif
                    end else begin
`ifdef SEQ_DETECT_TIMEOUT_EN
                        wd_d = WD_W'(wd_q + 1'b1);
                        if (wd_d == WD_W'(TIMEOUT_CYC)) begin
                            state_d   = S_DONE;
                            timeout_d = 1'b1;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= DEFAULT_PAT;
            len_q     <= LEN_MAX;
            overlap_q <= 1'b0;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SEQ_DETECT_TIMEOUT_EN
    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign cfg_ready = (state_q != S_RUN);
    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule
